// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - two-channel switch synchronizer and stability filter
// Each channel: 2-flop synchronizer, 4-state qualify FSM, registered level and edge pulses.

module switch_debouncer_chan #(
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic fire
);

  typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sync1;
  logic             sync2;

  // Qualification completes on the coming edge; lets the top register CHG alongside the pulses.
  always_comb begin
    fire = 1'b0;
    if (cnt == LAST) begin
      if (state == WAIT_HIGH && sync2)  fire = 1'b1;
      if (state == WAIT_LOW  && !sync2) fire = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= IDLE_LOW;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      case (state)
        IDLE_LOW: begin
          if (sync2) begin
            state <= WAIT_HIGH;
            cnt   <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!sync2) begin
            state <= IDLE_LOW;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
            level <= 1'b1;
            rise  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE_HIGH: begin
          if (!sync2) begin
            state <= WAIT_LOW;
            cnt   <= '0;
          end
        end
        WAIT_LOW: begin
          if (sync2) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= IDLE_LOW;
            cnt   <= '0;
            level <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

module switch_debouncer #(
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic SW_X,
  input  logic SW_Y,
  output logic X,
  output logic Y,
  output logic X_RISE,
  output logic X_FALL,
  output logic Y_RISE,
  output logic Y_FALL,
  output logic CHG
);

  logic x_fire;
  logic y_fire;

  switch_debouncer_chan #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_chan_x (
    .clk  (CLK),
    .rst  (RST),
    .sw   (SW_X),
    .level(X),
    .rise (X_RISE),
    .fall (X_FALL),
    .fire (x_fire)
  );

  switch_debouncer_chan #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_chan_y (
    .clk  (CLK),
    .rst  (RST),
    .sw   (SW_Y),
    .level(Y),
    .rise (Y_RISE),
    .fall (Y_FALL),
    .fire (y_fire)
  );

  // One CHG pulse even when both channels qualify on the same edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) CHG <= 1'b0;
    else     CHG <= x_fire | y_fire;
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - self-checking bench for switch_debouncer
// Reference: output flips after STABLE+1 consecutive synchronized samples that disagree with it.

module tb_switch_debouncer;

  localparam int STABLE = 4;
  localparam int CW     = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic SW_X = 1'b0;
  logic SW_Y = 1'b0;
  logic X, Y, X_RISE, X_FALL, Y_RISE, Y_FALL, CHG;

  int checks = 0;
  int errors = 0;

  logic m_s1 [2];
  logic m_s2 [2];
  logic m_out[2];
  int   m_run[2];

  int first_xr, first_xf, first_yr, first_chg, n_chg, n_xr, n_yr;

  switch_debouncer #(.STABLE_CYCLES(STABLE), .CNT_W(CW)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .SW_X  (SW_X),
    .SW_Y  (SW_Y),
    .X     (X),
    .Y     (Y),
    .X_RISE(X_RISE),
    .X_FALL(X_FALL),
    .Y_RISE(Y_RISE),
    .Y_FALL(Y_FALL),
    .CHG   (CHG)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic sx, input logic sy);
    logic sw[2];
    logic flip[2];
    RST  = r;
    SW_X = sx;
    SW_Y = sy;
    @(posedge CLK);
    #1;
    sw[0] = sx;
    sw[1] = sy;
    for (int c = 0; c < 2; c++) begin
      flip[c] = 1'b0;
      if (r) begin
        m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_out[c] = 1'b0; m_run[c] = 0;
      end else begin
        if (m_s2[c] != m_out[c]) begin
          m_run[c]++;
          if (m_run[c] == STABLE + 1) begin
            m_out[c] = ~m_out[c];
            m_run[c] = 0;
            flip[c]  = 1'b1;
          end
        end else begin
          m_run[c] = 0;
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = sw[c];
      end
    end
    check("x_level", X,      m_out[0]);
    check("y_level", Y,      m_out[1]);
    check("x_rise",  X_RISE, flip[0] &  m_out[0]);
    check("x_fall",  X_FALL, flip[0] & ~m_out[0]);
    check("y_rise",  Y_RISE, flip[1] &  m_out[1]);
    check("y_fall",  Y_FALL, flip[1] & ~m_out[1]);
    check("chg",     CHG,    flip[0] | flip[1]);
  endtask

  // Holds inputs for n edges and records 1-based edge indices of the first events.
  task automatic hold(input logic r, input logic sx, input logic sy, input int n);
    first_xr = 0; first_xf = 0; first_yr = 0; first_chg = 0;
    n_chg = 0; n_xr = 0; n_yr = 0;
    for (int i = 1; i <= n; i++) begin
      step(r, sx, sy);
      if (X_RISE) begin n_xr++; if (first_xr == 0) first_xr = i; end
      if (Y_RISE) begin n_yr++; if (first_yr == 0) first_yr = i; end
      if (X_FALL && first_xf == 0) first_xf = i;
      if (CHG) begin n_chg++; if (first_chg == 0) first_chg = i; end
    end
  endtask

  initial begin
    logic tx, ty, dx, dy, rr;
    int bounce_xr;
    for (int c = 0; c < 2; c++) begin
      m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_out[c] = 1'b0; m_run[c] = 0;
    end

    // Reset held with both switches high, then release
    hold(1'b1, 1'b1, 1'b1, 3);
    check("rst_no_chg", n_chg, 0);
    hold(1'b0, 1'b1, 1'b1, 12);
    check("rel_chg_edge", first_chg, 7);
    check("rel_xr_edge",  first_xr,  7);
    check("rel_yr_edge",  first_yr,  7);
    check("rel_chg_cnt",  n_chg,     1);

    // Clean step on X
    hold(1'b0, 1'b0, 1'b0, 12);
    hold(1'b0, 1'b1, 1'b0, 12);
    check("step_xr_edge", first_xr, 7);
    check("step_xr_cnt",  n_xr,     1);
    check("step_x_held",  X,        1);

    // Bounce then settle high
    hold(1'b0, 1'b0, 1'b0, 12);
    bounce_xr = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
      if (X_RISE) bounce_xr++;
    end
    check("bounce_no_rise", bounce_xr, 0);
    hold(1'b0, 1'b1, 1'b0, 12);
    check("bounce_settle_edge", first_xr, 7);

    // Short glitch from low
    hold(1'b0, 1'b0, 1'b0, 12);
    hold(1'b0, 1'b1, 1'b0, 3);
    check("glitch_no_rise_a", n_xr, 0);
    hold(1'b0, 1'b0, 1'b0, 12);
    check("glitch_no_rise_b", n_xr, 0);
    check("glitch_no_chg",    n_chg, 0);

    // Release from high
    hold(1'b0, 1'b1, 1'b0, 12);
    hold(1'b0, 1'b0, 1'b0, 12);
    check("fall_edge",     first_xf,  7);
    check("fall_chg_edge", first_chg, 7);

    // Simultaneous rise
    hold(1'b0, 1'b1, 1'b1, 12);
    check("sim_xr_edge", first_xr, 7);
    check("sim_yr_edge", first_yr, 7);
    check("sim_chg_cnt", n_chg,    1);

    // Mid-count reset
    hold(1'b0, 1'b0, 1'b0, 12);
    hold(1'b0, 1'b1, 1'b1, 4);
    check("mid_no_chg_pre", n_chg, 0);
    hold(1'b1, 1'b1, 1'b1, 2);
    check("mid_no_chg_rst", n_chg, 0);
    hold(1'b0, 1'b1, 1'b1, 12);
    check("mid_xr_edge", first_xr, 7);
    check("mid_yr_edge", first_yr, 7);

    // Random bouncy stimulus against the model
    tx = 1'b0; ty = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) tx = ~tx;
      if ($urandom_range(0, 9) == 0) ty = ~ty;
      dx = ($urandom_range(0, 5) == 0) ? ~tx : tx;
      dy = ($urandom_range(0, 5) == 0) ? ~ty : ty;
      rr = ($urandom_range(0, 299) == 0);
      step(rr, dx, dy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Two-channel input conditioner that sits directly upstream of the X/Y toggle state machine.
- Takes the raw, bouncy, asynchronous SW_X and SW_Y slide-switch/push-button lines.
- Delivers clean, clock-synchronous X and Y levels plus single-cycle edge pulses.
- Each channel runs a 2-flop synchronizer and a counter-based stability filter, so the downstream flip-flop only sees settled values.

Parameters:
- STABLE_CYCLES, 50000: consecutive synchronized samples that must differ from the current output before it changes. Range 1..2^CNT_W. 50000 gives 1 ms at 50 MHz.
- CNT_W, 16: stability counter width. Must hold STABLE_CYCLES-1.

Ports:
- CLK  input  1  system clock, rising-edge active
- RST  input  1  asynchronous, active-high reset
- SW_X  input  1  raw switch X, asynchronous to CLK
- SW_Y  input  1  raw switch Y, asynchronous to CLK
- X  output  1  debounced level of SW_X (registered)
- Y  output  1  debounced level of SW_Y (registered)
- X_RISE  output  1  one-cycle pulse when X goes 0->1
- X_FALL  output  1  one-cycle pulse when X goes 1->0
- Y_RISE  output  1  one-cycle pulse when Y goes 0->1
- Y_FALL  output  1  one-cycle pulse when Y goes 1->0
- CHG  output  1  one-cycle pulse when X or Y (or both) changed

Behaviour:
- One clock (CLK). Reset is asynchronous and active-high on RST.
- RST asserted at any time, including mid-count, immediately forces:
  - both synchronizer flops to 0
  - both FSMs to IDLE_LOW
  - both counters to 0
  - X, Y, all pulse outputs and CHG to 0
- Synchronizer: sync1 <= SW_n and sync2 <= sync1 on every rising edge. Only sync2 is used by the FSM.
- Per-channel FSM, identical and independent for X and Y. States:
  - IDLE_LOW: output 0. If sync2=1, go to WAIT_HIGH with cnt<=0.
  - WAIT_HIGH: output 0.
    - If sync2=0, return to IDLE_LOW with cnt<=0 (glitch rejected).
    - Else if cnt==STABLE_CYCLES-1, go to IDLE_HIGH, output<=1, RISE<=1 for exactly one cycle.
    - Else cnt<=cnt+1.
  - IDLE_HIGH: output 1. If sync2=0, go to WAIT_LOW with cnt<=0.
  - WAIT_LOW: mirror of WAIT_HIGH.
    - If sync2=1, return to IDLE_HIGH with cnt<=0.
    - Else if cnt==STABLE_CYCLES-1, go to IDLE_LOW, output<=0, FALL<=1 for one cycle.
    - Else cnt<=cnt+1.
- Pulses: RISE, FALL and CHG are registered and high for exactly one cycle. The output level changes on the same edge that raises the pulse.
- Latency: the raw input changes before edge 1 and stays stable. The output changes at edge STABLE_CYCLES+3:
  - 2 edges of synchronization
  - 1 edge to enter WAIT
  - STABLE_CYCLES edges to qualify
- Any sync2 reversal during WAIT restarts qualification from zero. Bounce shorter than STABLE_CYCLES samples never reaches the outputs.
- Simultaneous events:
  - X and Y qualifying on the same edge: both levels and both pulses update, and CHG is a single one-cycle pulse.
  - X changing on one edge and Y on the next: two separate CHG pulses.
- Counter never wraps: it is cleared on every WAIT entry and every exit.
- Reset release with a switch already held high: the output rises at edge STABLE_CYCLES+3 after release. No pulse is generated during reset.

Test Plan:
(Run with STABLE_CYCLES=4, CNT_W=3.)
- Reset check: RST=1, SW_X=SW_Y=1 -> X=Y=0 and all pulses 0 while RST is high. Release -> X, Y, X_RISE, Y_RISE and a single CHG all assert at edge 7 after release.
- Clean step: SW_X 0->1 before edge 1, held -> X=1 and X_RISE=1 at edge 7. X_RISE=0 at edge 8. X stays 1.
- Bounce rejection: SW_X toggles 1,0,1,0 each cycle for 8 cycles, then settles at 1 -> no X_RISE during the bounce. X rises exactly 7 edges after the final settle.
- Short glitch: SW_X high for 3 cycles then low -> X stays 0, no pulse, FSM returns to IDLE_LOW.
- Release: with X=1, SW_X 1->0 held -> X=0 and X_FALL=1 at edge 7, CHG=1 at the same edge.
- Simultaneous and mid-count reset:
  - SW_X and SW_Y rise together -> X_RISE and Y_RISE on the same edge, CHG one cycle.
  - Repeat with RST pulsed at edge 5 -> outputs stay 0, then rise 7 edges after release.
